code_decoder_seq: RTL and testbench

//  Sequential 3-to-8 decoder, the receive-side counterpart of the 8-input priority encoder.

---
 rtl/code_decoder_seq_pkg.sv | 30 +++
 rtl/code_decoder_seq_if.sv | 23 ++
 rtl/code_decoder_seq_dwell_counter.sv | 28 ++
 rtl/code_decoder_seq.sv | 119 +++++++++++
 tb/tb_code_decoder_seq.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/code_decoder_seq_pkg.sv
// Shared types for the sequential 3-to-8 decoder: state encoding, code/line types, polarity helpers.
// No logic of its own; latency and backpressure are owned by code_decoder_seq.
package code_decoder_seq_pkg;

  localparam int CW  = 3;
  localparam int N   = 1 << CW;
  localparam int DCW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef logic [CW-1:0]  code_t;
  typedef logic [N-1:0]   lines_t;
  typedef logic [DCW-1:0] dwell_t;

  function automatic lines_t idle_lines(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

  function automatic lines_t onehot_lines(input code_t c, input bit active_low);
    lines_t l;
    l    = '0;
    l[c] = 1'b1;
    return active_low ? ~l : l;
  endfunction

endpackage

// File: rtl/code_decoder_seq_if.sv
// Code handshake plus decoded select outputs of code_decoder_seq; slave side is the decoder.
// Pure wiring; timing and backpressure come from the decoder (in_ready high only in IDLE).
interface code_decoder_seq_if;
  import code_decoder_seq_pkg::*;

  code_t  code_in;
  logic   in_valid;
  logic   in_ready;
  lines_t dec_out;
  logic   out_active;
  logic   done;

  modport slave (
    input  code_in, in_valid,
    output in_ready, dec_out, out_active, done
  );

  modport master (
    output code_in, in_valid,
    input  in_ready, dec_out, out_active, done
  );

endinterface

// File: rtl/code_decoder_seq_dwell_counter.sv
// 8-bit down counter with synchronous load and a zero flag; one-cycle update latency.
// No handshake: load wins over decrement, and decrement saturates at zero.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/code_decoder_seq.sv
// Sequential 3-to-8 decoder: accept at edge k drives the line for k+1..k+DWELL, done pulse in k+DWELL+1.
// Backpressure: in_ready only in IDLE; optional DECODER_AUTOSCAN_EN adds scan_en self-issuing codes.
module code_decoder_seq
  import code_decoder_seq_pkg::*;
#(
  parameter int DWELL      = 4,   // legal range 1..255
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  code_decoder_seq_if.slave   bus
`ifdef DECODER_AUTOSCAN_EN
  ,
  input  logic                scan_en
`endif
);

  localparam dwell_t LOAD_VAL = dwell_t'(DWELL - 1);

  state_e r_state;
  state_e w_state_nxt;
  code_t  r_code;
  code_t  w_code_nxt;
  lines_t r_dec;
  logic   r_active;
  logic   r_done;
  logic   r_rdy;
  logic   w_accept;
  logic   w_cnt_dec;
  logic   w_cnt_zero;

`ifdef DECODER_AUTOSCAN_EN
  code_t  r_scan_code;
`endif

  dwell_counter #(.W(DCW)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_accept    = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_rdy stays low for the first cycle after reset release
        if (r_rdy && bus.in_valid) begin
          w_accept   = 1'b1;
          w_code_nxt = bus.code_in;
        end
`ifdef DECODER_AUTOSCAN_EN
        else if (r_rdy && scan_en) begin
          w_accept   = 1'b1;
          w_code_nxt = r_scan_code;
        end
`endif
        if (w_accept) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_code   <= '0;
      r_dec    <= idle_lines(ACTIVE_LOW);
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_dec    <= (w_state_nxt == ST_HOLD) ? onehot_lines(w_code_nxt, ACTIVE_LOW)
                                           : idle_lines(ACTIVE_LOW);
      r_active <= (w_state_nxt == ST_HOLD);
      r_done   <= (w_state_nxt == ST_GAP);
      r_rdy    <= (w_state_nxt == ST_IDLE);
    end
  end

`ifdef DECODER_AUTOSCAN_EN
  // Any accept, external or self-issued, sets the base for the next scan code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_code <= '0;
    end else if (w_accept) begin
      r_scan_code <= w_code_nxt + 1'b1;
    end
  end
`endif

  assign bus.in_ready   = r_rdy;
  assign bus.dec_out    = r_dec;
  assign bus.out_active = r_active;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_code_decoder_seq.sv
// Scoreboarded bench for code_decoder_seq (DWELL=4 main instance, DWELL=1 boundary instance).
// Define DECODER_AUTOSCAN_EN to also exercise the autoscan sequence.
module tb_code_decoder_seq;
  import code_decoder_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  code_decoder_seq_if bus4 ();
  code_decoder_seq_if bus1 ();

`ifdef DECODER_AUTOSCAN_EN
  logic scan_en4 = 1'b0;
`endif

  code_decoder_seq #(.DWELL(4), .ACTIVE_LOW(1'b1)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
`ifdef DECODER_AUTOSCAN_EN
    ,
    .scan_en (scan_en4)
`endif
  );

  code_decoder_seq #(.DWELL(1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
`ifdef DECODER_AUTOSCAN_EN
    ,
    .scan_en (1'b0)
`endif
  );

  // Hand-computed active-low patterns for codes 0..7
  lines_t exp_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  lines_t q[$];
  bit     trk = 1'b0;
  int     hold_n = 0;
  lines_t exp_line = 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected line per HOLD burst and checks the burst, its length and the GAP.
  always @(negedge clk) begin
    if (!rst_n) begin
      trk    = 1'b0;
      hold_n = 0;
    end else begin
      if (bus4.out_active || bus4.done) chk("rdy_low_busy", 32'(bus4.in_ready), 32'd0);
      if (bus4.out_active) begin
        if (!trk) begin
          if (q.size() == 0) begin
            chk("unexpected_hold", 32'd1, 32'd0);
            exp_line = 8'hFF;
          end else begin
            exp_line = q.pop_front();
          end
          trk    = 1'b1;
          hold_n = 0;
        end
        chk("hold_line", 32'(bus4.dec_out), 32'(exp_line));
        hold_n++;
      end else if (trk) begin
        chk("gap_done", 32'(bus4.done), 32'd1);
        chk("gap_lines", 32'(bus4.dec_out), 32'hFF);
        chk("hold_len", 32'(hold_n), 32'd4);
        trk = 1'b0;
      end else begin
        chk("idle_lines", 32'(bus4.dec_out), 32'hFF);
        chk("stray_done", 32'(bus4.done), 32'd0);
      end
    end
  end

  task automatic wait_rdy4();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus4.in_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input code_t c, input bit keep_valid, output int acc);
    @(negedge clk);
    bus4.code_in  = c;
    bus4.in_valid = 1'b1;
    wait_rdy4();
    @(posedge clk);
    #1;
    acc = cyc;
    if (!keep_valid) bus4.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !trk) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

`ifdef DECODER_AUTOSCAN_EN
  task automatic wait_q_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("scan_timeout", 32'd0, 32'd1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t1, t2, a;
    bit seen1;
    bus4.code_in = '0; bus4.in_valid = 1'b0;
    bus1.code_in = '0; bus1.in_valid = 1'b0;

    // Reset state
    #22;
    chk("rst_dec", 32'(bus4.dec_out), 32'hFF);
    chk("rst_active", 32'(bus4.out_active), 32'd0);
    chk("rst_done", 32'(bus4.done), 32'd0);
    chk("rst_rdy", 32'(bus4.in_ready), 32'd0);
    chk("rst_dec_d1", 32'(bus1.dec_out), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", 32'(bus4.in_ready), 32'd1);

    // Single code 3, then in_ready back one cycle after the done pulse
    q.push_back(exp_tab[3]);
    send(3'd3, 1'b0, a);
    repeat (5) @(posedge clk);
    #1;
    chk("rdy_after_done", 32'(bus4.in_ready), 32'd1);
    drain();

    // Boundary codes
    q.push_back(exp_tab[0]);
    send(3'd0, 1'b0, a);
    drain();
    q.push_back(exp_tab[7]);
    send(3'd7, 1'b0, a);
    drain();

    // DWELL=1 instance: single-cycle hold
    @(negedge clk);
    bus1.code_in  = 3'd0;
    bus1.in_valid = 1'b1;
    seen1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus1.in_ready) begin
        seen1 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen1) chk("d1_rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("d1_hold_line", 32'(bus1.dec_out), 32'hFE);
    chk("d1_hold_active", 32'(bus1.out_active), 32'd1);
    @(negedge clk);
    chk("d1_gap_line", 32'(bus1.dec_out), 32'hFF);
    chk("d1_gap_done", 32'(bus1.done), 32'd1);
    @(negedge clk);
    chk("d1_idle_rdy", 32'(bus1.in_ready), 32'd1);
    chk("d1_idle_done", 32'(bus1.done), 32'd0);

    // Back-to-back with in_valid held; code_in disturbed mid-HOLD
    q.push_back(exp_tab[2]);
    q.push_back(exp_tab[5]);
    send(3'd2, 1'b1, t1);
    bus4.code_in = 3'd5;
    @(posedge clk);
    #1;
    bus4.code_in = 3'd7;
    @(posedge clk);
    #1;
    bus4.code_in = 3'd5;
    @(negedge clk);
    wait_rdy4();
    @(posedge clk);
    #1;
    t2 = cyc;
    bus4.in_valid = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'd6);
    drain();

    // Reset in the second HOLD cycle
    q.push_back(exp_tab[6]);
    send(3'd6, 1'b0, a);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dec", 32'(bus4.dec_out), 32'hFF);
    chk("midrst_active", 32'(bus4.out_active), 32'd0);
    chk("midrst_done", 32'(bus4.done), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_clean_rdy", 32'(bus4.in_ready), 32'd1);

`ifdef DECODER_AUTOSCAN_EN
    // Autoscan from reset: 0..7 then wrap to 0
    for (int i = 0; i < 8; i++) q.push_back(exp_tab[i]);
    q.push_back(exp_tab[0]);
    @(negedge clk);
    scan_en4 = 1'b1;
    wait_q_empty();
    scan_en4 = 1'b0;
    drain();
    // External code 4 rebases the scan; next self-issued code is 5
    q.push_back(exp_tab[4]);
    send(3'd4, 1'b0, a);
    drain();
    q.push_back(exp_tab[5]);
    scan_en4 = 1'b1;
    wait_q_empty();
    scan_en4 = 1'b0;
    drain();
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
